qspi_tx_shift: RTL and testbench

QSPI_TX_SHIFT -- requirements
Module: qspi_tx_shift

---
 rtl/qspi_pkg.sv | 26 ++
 rtl/qspi_tx_shift.sv | 91 +++++++++
 tb/tb_qspi_tx_shift.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI transmit shifter.
// Holds the FSM state encoding and the byte-length encoding.
package qspi_pkg;

  localparam int QSPI_WORD_W = 32;
  localparam int QSPI_NIB_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // len_i encoding: bytes to send minus one
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  // index of the last nibble of a transfer: 2*len+1
  function automatic logic [2:0] nib_last(
    input logic [1:0] len
  );
    return {len, 1'b1};
  endfunction

endpackage

// File: rtl/qspi_tx_shift.sv
// Quad-SPI transmit shifter: one nibble per cycle,
// 1..4 bytes per word, selectable nibble order.
module qspi_tx_shift
  import qspi_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [QSPI_WORD_W-1:0] data_i,
  input  logic [1:0]             len_i,
  input  logic                   msb_first_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [QSPI_NIB_W-1:0]  qsd_o,
  output logic                   qsd_oe_o,
  output logic                   busy_o,
  output logic                   done_o
);

  state_e                 state_q, state_d;
  logic [QSPI_WORD_W-1:0] sreg_q, sreg_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   msb_q, msb_d;
  logic                   done_q, done_d;

  // MSB-first words are left-aligned so the top nibble
  // always leaves from [31:28]; LSB-first words are
  // masked and leave from [3:0].
  logic [4:0]             shamt;
  logic [QSPI_WORD_W-1:0] load_msb;
  logic [QSPI_WORD_W-1:0] load_lsb;

  assign shamt    = {~len_i, 3'b000};
  assign load_msb = data_i << shamt;
  assign load_lsb = data_i & ({QSPI_WORD_W{1'b1}} >> shamt);

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      done_q  <= done_d;
    end
  end

  // next-state: load on accept, shift and count in SHIFT
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    msb_d   = msb_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d = SHIFT;
          cnt_d   = nib_last(len_i);
          msb_d   = msb_first_i;
          sreg_d  = msb_first_i ? load_msb : load_lsb;
        end
      end
      SHIFT: begin
        sreg_d = msb_q ? (sreg_q << QSPI_NIB_W)
                       : (sreg_q >> QSPI_NIB_W);
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == SHIFT);
  assign qsd_oe_o = busy_o;
  assign done_o   = done_q;
  assign qsd_o    = !qsd_oe_o ? '0
                  : msb_q     ? sreg_q[QSPI_WORD_W-1 -: QSPI_NIB_W]
                              : sreg_q[QSPI_NIB_W-1:0];

endmodule

// File: tb/tb_qspi_tx_shift.sv
// Self-checking bench for qspi_tx_shift.
// Reference nibbles computed directly from data/len/order.
module tb_qspi_tx_shift;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] data_i = '0;
  logic [1:0]  len_i = '0;
  logic        msb_first_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [3:0]  qsd_o;
  logic        qsd_oe_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_bad = 0;

  qspi_tx_shift dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .len_i       (len_i),
    .msb_first_i (msb_first_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .qsd_o       (qsd_o),
    .qsd_oe_o    (qsd_oe_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // k-th nibble on the bus for a given word
  function automatic logic [3:0] exp_nib(
    input logic [31:0] d,
    input int          len,
    input bit          msb,
    input int          k
  );
    int idx;
    idx = msb ? (2*len + 1 - k) : k;
    return d[4*idx +: 4];
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({ready_o, busy_o, qsd_oe_o, done_o, qsd_o} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 10000000",
               {ready_o, busy_o, qsd_oe_o, done_o, qsd_o});
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    n_cmp++;
    if ({ready_o, busy_o, qsd_oe_o, done_o, qsd_o} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b want 10000000",
               {ready_o, busy_o, qsd_oe_o, done_o, qsd_o});
    end
  endtask

  // directed words, incl. len 0 with upper-byte garbage
  task automatic test_vectors();
    logic [31:0] vd [4] = '{32'h12345678, 32'h12345678,
                            32'hFFFFFFAB, 32'hFFFFFFAB};
    int          vl [4] = '{3, 3, 0, 0};
    bit          vm [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  ex [4][8] = '{
      '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8},
      '{4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1},
      '{4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0},
      '{4'hB, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0}};
    for (int v = 0; v < 4; v++) begin
      data_i      = vd[v];
      len_i       = 2'(vl[v]);
      msb_first_i = vm[v];
      valid_i     = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int k = 0; k < 2*(vl[v]+1); k++) begin
        n_cmp++;
        if (qsd_o !== ex[v][k] || qsd_oe_o !== 1'b1 ||
            busy_o !== 1'b1 || ready_o !== 1'b0 || done_o !== 1'b0) begin
          n_bad++;
          $display("FAIL vec%0d_nib%0d: got qsd=%h oe=%b busy=%b rdy=%b done=%b want qsd=%h oe=1 busy=1 rdy=0 done=0",
                   v, k, qsd_o, qsd_oe_o, busy_o, ready_o, done_o, ex[v][k]);
        end
        tick();
      end
      n_cmp++;
      if (done_o !== 1'b1 || qsd_oe_o !== 1'b0 || qsd_o !== 4'h0 ||
          ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL vec%0d_done: got done=%b oe=%b qsd=%h rdy=%b want 1 0 0 1",
                 v, done_o, qsd_oe_o, qsd_o, ready_o);
      end
      tick();
      n_cmp++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL vec%0d_done_width: got done=%b busy=%b want 0 0",
                 v, done_o, busy_o);
      end
    end
  endtask

  // random words, random gaps, junk inputs during SHIFT
  task automatic test_random();
    logic [31:0] d;
    int          len;
    bit          msb;
    int          gap;
    for (int t = 0; t < 40; t++) begin
      d   = $urandom;
      len = $urandom_range(0, 3);
      msb = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      data_i      = d;
      len_i       = 2'(len);
      msb_first_i = msb;
      valid_i     = 1'b1;
      tick();
      for (int k = 0; k < 2*(len+1); k++) begin
        n_cmp++;
        if (qsd_o !== exp_nib(d, len, msb, k) || qsd_oe_o !== 1'b1 ||
            done_o !== 1'b0 || ready_o !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd%0d_nib%0d: got qsd=%h oe=%b done=%b rdy=%b want qsd=%h oe=1 done=0 rdy=0",
                   t, k, qsd_o, qsd_oe_o, done_o, ready_o,
                   exp_nib(d, len, msb, k));
        end
        valid_i     = 1'($urandom_range(0, 1));
        data_i      = $urandom;
        len_i       = 2'($urandom_range(0, 3));
        msb_first_i = 1'($urandom_range(0, 1));
        tick();
      end
      valid_i = 1'b0;
      n_cmp++;
      if (done_o !== 1'b1 || qsd_oe_o !== 1'b0 || qsd_o !== 4'h0) begin
        n_bad++;
        $display("FAIL rnd%0d_done: got done=%b oe=%b qsd=%h want 1 0 0",
                 t, done_o, qsd_oe_o, qsd_o);
      end
      for (int g = 0; g < gap; g++) begin
        tick();
        n_cmp++;
        if (done_o !== 1'b0 || qsd_oe_o !== 1'b0 || ready_o !== 1'b1) begin
          n_bad++;
          $display("FAIL rnd%0d_gap%0d: got done=%b oe=%b rdy=%b want 0 0 1",
                   t, g, done_o, qsd_oe_o, ready_o);
        end
      end
    end
    tick();
  endtask

  // valid held across two words: second taken in done cycle
  task automatic test_back_to_back();
    logic [31:0] w [2] = '{32'hA1B2C3D4, 32'h0000_5E6F};
    int          ln [2] = '{3, 1};
    bit          ms [2] = '{1'b1, 1'b0};
    int          accepts = 0;
    data_i      = w[0];
    len_i       = 2'(ln[0]);
    msb_first_i = ms[0];
    valid_i     = 1'b1;
    tick();
    data_i      = w[1];
    len_i       = 2'(ln[1]);
    msb_first_i = ms[1];
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 2*(ln[s]+1); k++) begin
        n_cmp++;
        if (qsd_o !== exp_nib(w[s], ln[s], ms[s], k) ||
            qsd_oe_o !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_w%0d_nib%0d: got qsd=%h oe=%b want qsd=%h oe=1",
                   s, k, qsd_o, qsd_oe_o, exp_nib(w[s], ln[s], ms[s], k));
        end
        tick();
      end
      n_cmp++;
      if (done_o !== 1'b1 || qsd_oe_o !== 1'b0 || ready_o !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_w%0d_gap: got done=%b oe=%b rdy=%b want 1 0 1",
                 s, done_o, qsd_oe_o, ready_o);
      end
      if (s == 1) valid_i = 1'b0;
      tick();
      if (s == 0) valid_i = 1'b0;
    end
    n_cmp++;
    if (busy_o !== 1'b0 || qsd_oe_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_no_dup: got busy=%b oe=%b done=%b want 0 0 0",
               busy_o, qsd_oe_o, done_o);
    end
    accepts = accepts;
  endtask

  // async reset after three nibbles, then a clean word
  task automatic test_reset_mid();
    logic [3:0] ex [8] = '{4'hC, 4'hA, 4'hF, 4'hE,
                           4'hB, 4'hA, 4'hB, 4'hE};
    data_i      = 32'h87654321;
    len_i       = 2'd3;
    msb_first_i = 1'b1;
    valid_i     = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (qsd_o !== exp_nib(32'h87654321, 3, 1'b1, k)) begin
        n_bad++;
        $display("FAIL rstmid_nib%0d: got %h want %h",
                 k, qsd_o, exp_nib(32'h87654321, 3, 1'b1, k));
      end
      tick();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({ready_o, busy_o, qsd_oe_o, done_o, qsd_o} !== 8'b1000_0000) begin
      n_bad++;
      $display("FAIL rstmid_async: got %b want 10000000",
               {ready_o, busy_o, qsd_oe_o, done_o, qsd_o});
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || ready_o !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_no_done: got done=%b busy=%b rdy=%b want 0 0 1",
               done_o, busy_o, ready_o);
    end
    data_i      = 32'hCAFEBABE;
    len_i       = 2'd3;
    msb_first_i = 1'b1;
    valid_i     = 1'b1;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (qsd_o !== ex[k] || qsd_oe_o !== 1'b1) begin
        n_bad++;
        $display("FAIL cafe_nib%0d: got qsd=%h oe=%b want qsd=%h oe=1",
                 k, qsd_o, qsd_oe_o, ex[k]);
      end
      tick();
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL cafe_done: got %b want 1", done_o);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
